// File: rtl/mult_pkg.sv
// Shared types for the iterative shift-add multiplier.
package mult_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  localparam int MAX_WIDTH = 32;
endpackage

// File: rtl/mux2.sv
// Generic two-input multiplexer.
module mux2 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             s,
  output logic [WIDTH-1:0] y
);
  assign y = s ? d1 : d0;
endmodule

// File: rtl/seq_mult_ctrl.sv
// Unsigned shift-add multiplier: one partial-product step per cycle, WIDTH steps per product.
module seq_mult_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  mult_state_t        state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] p_shift;

  mux2 #(.WIDTH(WIDTH)) u_addend_mux (
    .d0 ('0),
    .d1 (mcand_q),
    .s  (p_q[0]),
    .y  (addend)
  );

  // Carry out of the accumulator add becomes the new MSB after the right shift.
  assign sum     = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
  assign p_shift = {sum, p_q[WIDTH-1:1]};

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    p_d       = p_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = a;
          p_d     = {{WIDTH{1'b0}}, b};
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        p_d   = p_shift;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          product_d = p_shift;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      p_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      p_q       <= p_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == RUN) || (state_q == DONE);
  assign done    = (state_q == DONE);
  assign product = product_q;
endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Scoreboard bench for seq_mult_ctrl at WIDTH=8.
module tb_seq_mult_ctrl;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  typedef struct {
    logic [2*W-1:0] prod;
    int             due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  seq_mult_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: every done cycle must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=product %0d required=no done", product);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("product", 32'(product), 32'(e.prod));
        check("done_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  // Present operands at a falling edge; expectation is logged at the accepting edge.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    a = ia;
    b = ib;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 8'h5A;
    b = 8'hC3;
    e.prod = 16'(ia) * 16'(ib);
    e.due  = cyc + W;
    sb.push_back(e);
    check("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=no done required=done within 40 cycles");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for three cycles
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_product", 32'(product), 32'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // 13 x 11 with a stray start mid-run that must be ignored
    issue(8'd13, 8'd11);
    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    a = 8'd2;
    b = 8'd2;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (4) @(negedge clk);
    check("hold_after_done", 32'(product), 32'd143);
    check("idle_busy", 32'(busy), 32'd0);
    check("no_queued_start", 32'(sb.size()), 32'd0);

    // Full-scale operands: carry into the top bit
    issue(8'hFF, 8'hFF);
    wait_done();
    @(negedge clk);

    // Zero multiplicand still takes the full latency; old product held mid-run
    issue(8'h00, 8'hA5);
    repeat (3) @(negedge clk);
    check("hold_during_run", 32'(product), 32'hFE01);
    wait_done();
    @(negedge clk);

    // Asynchronous reset mid-operation aborts without a done
    issue(8'd200, 8'd3);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    sb.delete();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_product", 32'(product), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    check("abort_no_done", 32'(done), 32'd0);
    issue(8'd200, 8'd3);
    wait_done();
    @(negedge clk);

    // start held high: back-to-back products every WIDTH+2 cycles
    @(negedge clk);
    start = 1'b1;
    a = 8'd5;
    b = 8'd6;
    for (int k = 0; k < 3; k++) begin
      exp_t e;
      @(posedge clk);
      #1;
      check("held_accept_busy", 32'(busy), 32'd1);
      e.prod = 16'd30;
      e.due  = cyc + W;
      sb.push_back(e);
      a = 8'd99;
      b = 8'd77;
      if (k == 2) begin
        start = 1'b0;
      end else begin
        repeat (5) @(posedge clk);
        #1;
        a = 8'd5;
        b = 8'd6;
        repeat (4) @(posedge clk);
      end
    end
    wait_done();
    repeat (3) @(negedge clk);
    check("final_product", 32'(product), 32'd30);
    check("queue_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
